// File: rtl/ro_cache_pkg.sv
// Shared read-only cache definitions: default geometry and line-fill FSM states.
package ro_cache_pkg;

  localparam int unsigned DefLineWidth = 32;
  localparam int unsigned DefWordWidth = 4;
  localparam int unsigned DefBeatWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDone
  } lfb_state_e;

endpackage

// File: rtl/bin2onehot.sv
// Combinational binary-to-one-hot decoder.
module bin2onehot #(
  parameter int unsigned IN_W  = 3,
  parameter int unsigned OUT_W = 8
) (
  input  logic [IN_W-1:0]  bin,
  output logic [OUT_W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      onehot[i] = (bin == IN_W'(i));
    end
  end

endmodule

// File: rtl/line_fill_buf.sv
// Line fill buffer: assembles refill beats into a cache line and presents it with a
// registered one-hot word select for the downstream word-select mux.
module line_fill_buf
  import ro_cache_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = DefLineWidth,
  parameter int unsigned WORD_WIDTH = DefWordWidth,
  parameter int unsigned BEAT_WIDTH = DefBeatWidth,
  localparam int unsigned NUM_WORDS = LINE_WIDTH / WORD_WIDTH,
  localparam int unsigned NUM_BEATS = LINE_WIDTH / BEAT_WIDTH,
  localparam int unsigned OFS_W     = $clog2(NUM_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [OFS_W-1:0]      req_offset,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [BEAT_WIDTH-1:0] mem_data,
  input  logic                  mem_last,
  output logic                  line_valid,
  input  logic                  line_ready,
  output logic [LINE_WIDTH-1:0] line_data,
  output logic [NUM_WORDS-1:0]  line_sel,
  output logic                  err
);

  localparam int unsigned CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  lfb_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LINE_WIDTH-1:0] line_data_q, line_data_d;
  logic [NUM_WORDS-1:0]  line_sel_q, line_sel_d;
  logic [NUM_WORDS-1:0]  sel_dec;
  logic                  err_q, err_d;
  logic                  last_beat;

  bin2onehot #(
    .IN_W  (OFS_W),
    .OUT_W (NUM_WORDS)
  ) u_bin2onehot (
    .bin    (req_offset),
    .onehot (sel_dec)
  );

  assign last_beat = (cnt_q == CNT_W'(NUM_BEATS - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_data_d = line_data_q;
    line_sel_d  = line_sel_q;
    err_d       = 1'b0;
    req_ready   = 1'b0;
    mem_ready   = 1'b0;
    line_valid  = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          line_sel_d = sel_dec;
          cnt_d      = '0;
          state_d    = StFill;
        end
      end
      StFill: begin
        mem_ready = 1'b1;
        if (mem_valid) begin
          for (int unsigned b = 0; b < NUM_BEATS; b++) begin
            if (cnt_q == CNT_W'(b)) begin
              line_data_d[b*BEAT_WIDTH +: BEAT_WIDTH] = mem_data;
            end
          end
          // mem_last is only advisory; the beat count alone ends the fill.
          err_d = (mem_last != last_beat);
          if (last_beat) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        line_valid = 1'b1;
        if (line_ready) begin
          line_sel_d = '0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      line_data_q <= '0;
      line_sel_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_data_q <= line_data_d;
      line_sel_q  <= line_sel_d;
      err_q       <= err_d;
    end
  end

  assign line_data = line_data_q;
  assign line_sel  = line_sel_q;
  assign err       = err_q;

endmodule

// File: tb/tb_line_fill_buf.sv
// Scoreboard bench for line_fill_buf: directed scenarios plus randomized fills.
module tb_line_fill_buf;

  localparam int LW = 32;
  localparam int WW = 4;
  localparam int BW = 8;
  localparam int NB = LW / BW;
  localparam int NW = LW / WW;
  localparam int OW = $clog2(NW);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [OW-1:0] req_offset = '0;
  logic          mem_valid = 1'b0;
  logic          mem_ready;
  logic [BW-1:0] mem_data = '0;
  logic          mem_last = 1'b0;
  logic          line_valid;
  logic          line_ready = 1'b0;
  logic [LW-1:0] line_data;
  logic [NW-1:0] line_sel;
  logic          err;

  int     checks = 0;
  int     errors = 0;
  longint cycle = 0;

  typedef struct packed {
    logic [LW-1:0] data;
    logic [NW-1:0] sel;
  } line_t;

  line_t exp_lines[$];
  bit    exp_err[$];

  line_fill_buf #(
    .LINE_WIDTH (LW),
    .WORD_WIDTH (WW),
    .BEAT_WIDTH (BW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_offset (req_offset),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_data   (mem_data),
    .mem_last   (mem_last),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .line_data  (line_data),
    .line_sel   (line_sel),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: condition violated at cycle %0d", name, cycle);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    check({tag, "_mem_ready"}, 64'(mem_ready), 64'd0);
    check({tag, "_line_valid"}, 64'(line_valid), 64'd0);
    check({tag, "_line_data"}, 64'(line_data), 64'd0);
    check({tag, "_line_sel"}, 64'(line_sel), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
  endtask

  // Issue one request and nbeats refill beats; a full fill is then consumed after hold cycles.
  task automatic do_fill(input logic [OW-1:0] ofs, input logic [LW-1:0] line,
                         input logic [NB-1:0] lasts, input int gap, input int hold,
                         input bit keep_req, input int nbeats);
    int            n;
    longint        cv;
    logic [NW-1:0] s;
    req_valid  = 1'b1;
    req_offset = ofs;
    n = 0;
    while (!req_ready && n < 100) begin tick(); n++; end
    if (!req_ready) fail("req_ready_timeout");
    tick();
    if (!keep_req) req_valid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (i > 0) repeat (gap) tick();
      mem_valid = 1'b1;
      mem_data  = line[i*BW +: BW];
      mem_last  = lasts[i];
      n = 0;
      while (!mem_ready && n < 100) begin tick(); n++; end
      if (!mem_ready) fail("mem_ready_timeout");
      exp_err.push_back(lasts[i] != (i == NB - 1));
      if (i == NB - 1) begin
        s = '0;
        s[ofs] = 1'b1;
        exp_lines.push_back({line, s});
      end
      tick();
      mem_valid = 1'b0;
      mem_last  = 1'b0;
    end
    if (nbeats < NB) return;
    n = 0;
    while (!line_valid && n < 50) begin tick(); n++; end
    if (!line_valid) fail("line_valid_timeout");
    cv = cycle;
    repeat (hold) tick();
    line_ready = 1'b1;
    tick();
    line_ready = 1'b0;
    if (keep_req) begin
      n = 0;
      while (!req_ready && n < 50) begin tick(); n++; end
      check("req_turnaround", 64'(cycle - cv), 64'(hold + 1));
    end
  endtask

  // Monitor: tracks handshakes and checks err, line latency, line contents and stability.
  initial begin
    int            seen;
    bit            pend;
    bit            lastflag;
    logic          prev_lv;
    logic          prev_lr;
    logic [LW-1:0] prev_d;
    logic [NW-1:0] prev_s;
    line_t         e;
    seen = 0; pend = 0; lastflag = 0; prev_lv = 0; prev_lr = 0; prev_d = '0; prev_s = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 0; pend = 0; lastflag = 0; prev_lv = 0; prev_lr = 0;
        continue;
      end
      if (pend) begin
        if (exp_err.size() == 0) fail("err_queue_empty");
        else check("err_after_beat", 64'(err), 64'(exp_err.pop_front()));
      end else begin
        check("err_quiet", 64'(err), 64'd0);
      end
      if (lastflag) check("line_valid_latency", 64'(line_valid), 64'd1);
      if (line_valid && seen < NB) fail("line_valid_early");
      if (line_valid && !prev_lv) begin
        if (exp_lines.size() == 0) fail("line_unexpected");
        else begin
          e = exp_lines.pop_front();
          check("line_data", 64'(line_data), 64'(e.data));
          check("line_sel", 64'(line_sel), 64'(e.sel));
        end
      end
      if (line_valid && prev_lv && !prev_lr) begin
        check("line_data_stable", 64'(line_data), 64'(prev_d));
        check("line_sel_stable", 64'(line_sel), 64'(prev_s));
      end
      if (req_ready) check("line_sel_idle", 64'(line_sel), 64'd0);
      if (req_ready && (mem_ready || line_valid)) fail("req_ready_while_busy");
      pend = 0;
      lastflag = 0;
      if (req_valid && req_ready) seen = 0;
      if (mem_valid && mem_ready) begin
        seen++;
        pend = 1;
        lastflag = (seen == NB);
      end
      prev_lv = line_valid;
      prev_lr = line_ready;
      prev_d  = line_data;
      prev_s  = line_sel;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete by cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OW-1:0] ofs;
    logic [LW-1:0] line;
    logic [NB-1:0] lasts;
    repeat (3) tick();
    check_reset_state("por");
    rst = 1'b0;
    tick();

    // Back-to-back beats, offset 5.
    do_fill(3'd5, 32'h7654_3210, 4'b1000, 0, 0, 1'b0, NB);
    // Gapped beats and a delayed consumer.
    do_fill(3'd5, 32'h7654_3210, 4'b1000, 2, 3, 1'b0, NB);
    // mem_last early on beat 2 and missing on beat 4.
    do_fill(3'd2, 32'h7654_3210, 4'b0010, 0, 1, 1'b0, NB);

    // Abandon a fill after two beats; a mismatching beat during reset must not raise err.
    do_fill(3'd3, 32'h1122_3344, 4'b0000, 0, 0, 1'b0, 2);
    tick();
    mem_valid = 1'b1;
    mem_data  = 8'hEE;
    mem_last  = 1'b1;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
    mem_valid = 1'b0;
    mem_last  = 1'b0;
    check_reset_state("mid_rst");
    do_fill(3'd0, 32'hDDCC_BBAA, 4'b1000, 0, 0, 1'b0, NB);

    // Request held high across fill; the next request must wait for the bubble.
    do_fill(3'd1, 32'hCAFE_F00D, 4'b1000, 0, 0, 1'b1, NB);
    do_fill(3'd7, 32'h0BAD_BEEF, 4'b1000, 1, 0, 1'b0, NB);

    for (int t = 0; t < 30; t++) begin
      ofs   = OW'($urandom_range(0, NW - 1));
      line  = LW'($urandom);
      lasts = ($urandom_range(0, 3) == 0) ? NB'($urandom_range(0, 15)) : 4'b1000;
      do_fill(ofs, line, lasts, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), NB);
    end
    req_valid = 1'b0;
    repeat (5) tick();
    check("lines_outstanding", 64'(exp_lines.size()), 64'd0);
    check("err_outstanding", 64'(exp_err.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
